// File: rtl/mem_port_arbiter.sv
// Shares one Gowin_DPB_16k port between the arduino_io side (requester 0) and the
// processor_core side (requester 1): one command at a time, registered read return.

module mem_port_arbiter_rd (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cap_i,
  input  logic [7:0] din_i,
  output logic       rvalid_o,
  output logic [7:0] rdata_o
);
  logic       rvalid_q;
  logic [7:0] rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= cap_i;
      if (cap_i) rdata_q <= din_i;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
endmodule

module mem_port_arbiter #(
  parameter int READ_LATENCY   = 1,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic        sysclk,
  input  logic        arduino_reset,
  input  logic        req0_req,
  input  logic        req0_we,
  input  logic [13:0] req0_addr,
  input  logic [7:0]  req0_wdata,
  output logic        req0_gnt,
  output logic        req0_rvalid,
  output logic [7:0]  req0_rdata,
  input  logic        req1_req,
  input  logic        req1_we,
  input  logic [13:0] req1_addr,
  input  logic [7:0]  req1_wdata,
  output logic        req1_gnt,
  output logic        req1_rvalid,
  output logic [7:0]  req1_rdata,
  output logic [13:0] mem_ad,
  output logic [7:0]  mem_din,
  output logic        mem_wre,
  output logic        mem_ce,
  output logic        mem_oce,
  output logic        mem_clk,
  input  logic [7:0]  mem_dout,
  output logic        busy
);
  localparam int         NUM_REQ = 2;
  localparam logic [1:0] RL      = 2'(READ_LATENCY);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_rl
    $error("mem_port_arbiter: READ_LATENCY must be 1 or 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;
  typedef struct packed {
    logic        we;
    logic [13:0] addr;
    logic [7:0]  wdata;
  } cmd_t;

  state_e                    state_q, state_d;
  logic [1:0]                cnt_q, cnt_d;
  logic                      last_q, last_d;
  logic                      win_q, win_d;
  logic                      pick;
  cmd_t                      cmd_q, cmd_d;
  logic [NUM_REQ-1:0]        req, gnt, cap, rvalid;
  cmd_t [NUM_REQ-1:0]        req_cmd;
  logic [NUM_REQ-1:0][7:0]   rdata;

  assign req        = {req1_req, req0_req};
  assign req_cmd[0] = {req0_we, req0_addr, req0_wdata};
  assign req_cmd[1] = {req1_we, req1_addr, req1_wdata};

  always_ff @(posedge sysclk or negedge arduino_reset) begin
    if (!arduino_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      win_q   <= win_d;
      cmd_q   <= cmd_d;
    end
  end

  // On a conflict round-robin favours whoever did not win last time.
  always_comb begin
    pick = 1'b0;
    if (req == 2'b10)      pick = 1'b1;
    else if (req == 2'b11) pick = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    win_d   = win_q;
    cmd_d   = cmd_q;
    gnt     = '0;
    cap     = '0;
    mem_ce  = 1'b0;
    mem_wre = 1'b0;
    mem_oce = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          win_d   = pick;
          last_d  = pick;
          cmd_d   = req_cmd[pick];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        gnt[win_q] = 1'b1;
        mem_ce     = 1'b1;
        mem_wre    = cmd_q.we;
        if (cmd_q.we) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = RL;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        mem_oce = 1'b1;
        cnt_d   = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          cap[win_q] = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rd
    mem_port_arbiter_rd u_rd (
      .clk      (sysclk),
      .rst_n    (arduino_reset),
      .cap_i    (cap[i]),
      .din_i    (mem_dout),
      .rvalid_o (rvalid[i]),
      .rdata_o  (rdata[i])
    );
  end

  // Address/data simply hold the last command; ce/wre/oce gate all activity.
  assign mem_ad      = cmd_q.addr;
  assign mem_din     = cmd_q.wdata;
  assign mem_clk     = sysclk;
  assign busy        = (state_q != S_IDLE);
  assign req0_gnt    = gnt[0];
  assign req1_gnt    = gnt[1];
  assign req0_rvalid = rvalid[0];
  assign req1_rvalid = rvalid[1];
  assign req0_rdata  = rdata[0];
  assign req1_rdata  = rdata[1];
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 is bypass/round-robin, instance 1 is
// pipelined/fixed-priority, each with its own block-memory model and scoreboard.

module tb_mem_port_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n [2];
  logic [1:0]  req   [2];
  logic [1:0]  we    [2];
  logic [13:0] addr  [2][2];
  logic [7:0]  wdata [2][2];
  wire  [1:0]  gnt   [2];
  wire  [1:0]  rvalid[2];
  wire  [7:0]  rdata [2][2];
  wire  [13:0] mem_ad [2];
  wire  [7:0]  mem_din[2];
  wire         mem_wre[2], mem_ce[2], mem_oce[2], mem_clk[2], busy[2];
  wire  [7:0]  mem_dout[2];

  for (genvar d = 0; d < 2; d++) begin : g_dut
    mem_port_arbiter #(.READ_LATENCY(d + 1), .FIXED_PRIORITY(d)) u_dut (
      .sysclk(clk), .arduino_reset(rst_n[d]),
      .req0_req(req[d][0]), .req0_we(we[d][0]), .req0_addr(addr[d][0]), .req0_wdata(wdata[d][0]),
      .req0_gnt(gnt[d][0]), .req0_rvalid(rvalid[d][0]), .req0_rdata(rdata[d][0]),
      .req1_req(req[d][1]), .req1_we(we[d][1]), .req1_addr(addr[d][1]), .req1_wdata(wdata[d][1]),
      .req1_gnt(gnt[d][1]), .req1_rvalid(rvalid[d][1]), .req1_rdata(rdata[d][1]),
      .mem_ad(mem_ad[d]), .mem_din(mem_din[d]), .mem_wre(mem_wre[d]), .mem_ce(mem_ce[d]),
      .mem_oce(mem_oce[d]), .mem_clk(mem_clk[d]), .mem_dout(mem_dout[d]), .busy(busy[d])
    );
  end

  // Block memory models: instance 0 bypass, instance 1 with output register.
  logic [7:0] mem [2][16384];
  logic [7:0] arr_q [2];
  logic [7:0] oreg_q;
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      if (mem_ce[d]) begin
        if (mem_wre[d]) mem[d][mem_ad[d]] <= mem_din[d];
        else            arr_q[d] <= mem[d][mem_ad[d]];
      end
    if (mem_oce[1]) oreg_q <= arr_q[1];
  end
  assign mem_dout[0] = arr_q[0];
  assign mem_dout[1] = oreg_q;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rl_of(input int d);
    return d + 1;
  endfunction

  // Scoreboard, indexed by 2*instance+requester.
  logic [7:0] exp_mem [2][16384];
  logic [7:0] sb_q  [4][$];
  int         due_q [4][$];
  int         oce_n [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_n[d]) begin
        if (mem_oce[d]) oce_n[d]++;
        for (int r = 0; r < 2; r++) begin
          int k;
          k = 2 * d + r;
          if (gnt[d][r]) begin
            chk("gnt_needs_req", 32'(req[d][r]), 32'd1);
            chk("issue_ce", 32'(mem_ce[d]), 32'd1);
            chk("issue_wre", 32'(mem_wre[d]), 32'(we[d][r]));
            chk("issue_ad", 32'(mem_ad[d]), 32'(addr[d][r]));
            if (we[d][r]) begin
              chk("issue_din", 32'(mem_din[d]), 32'(wdata[d][r]));
              exp_mem[d][addr[d][r]] = wdata[d][r];
            end else begin
              due_q[k].push_back(cyc + rl_of(d) + 1);
              oce_n[d] = 0;
            end
          end
          if (rvalid[d][r]) begin
            if (due_q[k].size() == 0 || sb_q[k].size() == 0) begin
              chk("rvalid_spurious", 32'd1, 32'd0);
            end else begin
              chk("rv_latency", cyc, due_q[k].pop_front());
              chk("rdata", 32'(rdata[d][r]), 32'(sb_q[k].pop_front()));
              chk("oce_cycles", oce_n[d], rl_of(d));
              chk("busy_at_rv", 32'(busy[d]), 32'd0);
            end
          end else if (due_q[k].size() != 0 && cyc > due_q[k][0]) begin
            chk("rvalid_missing", 32'd0, 32'd1);
            void'(due_q[k].pop_front());
            if (sb_q[k].size() != 0) void'(sb_q[k].pop_front());
          end
        end
      end
    end
  end

  task automatic clear_sb(input int d);
    for (int r = 0; r < 2; r++) begin
      sb_q[2 * d + r].delete();
      due_q[2 * d + r].delete();
    end
  endtask

  task automatic access(input int d, input int r, input bit w, input logic [13:0] a,
                        input logic [7:0] wd, input bit lat, output int gc);
    int t;
    bit got;
    t = cyc;
    we[d][r] = w; addr[d][r] = a; wdata[d][r] = wd;
    if (!w) sb_q[2 * d + r].push_back(exp_mem[d][a]);
    req[d][r] = 1'b1;
    got = 1'b0;
    gc  = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (gnt[d][r]) begin got = 1'b1; gc = cyc; end
    end
    if (!got) chk("gnt_timeout", 32'd0, 32'd1);
    else if (lat) chk("gnt_latency", gc, t + 1);
    @(posedge clk); #1;
    req[d][r] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while ((busy[d] || sb_q[2*d].size() != 0 || sb_q[2*d+1].size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic reset_dut(input int d);
    @(negedge clk);
    rst_n[d] = 1'b0;
    clear_sb(d);
    repeat (2) @(negedge clk);
    rst_n[d] = 1'b1;
  endtask

  task automatic contend(input int d);
    int gc[8];
    bit gw[8];
    int n;
    n = 0;
    we[d] = 2'b11;
    addr[d][0] = 14'h0100; wdata[d][0] = 8'h33;
    addr[d][1] = 14'h0200; wdata[d][1] = 8'h44;
    req[d] = 2'b11;
    for (int i = 0; i < 60 && n < 8; i++) begin
      @(negedge clk);
      if (gnt[d] != 2'b00) begin gc[n] = cyc; gw[n] = gnt[d][1]; n++; end
    end
    #1 req[d] = 2'b00;
    chk("ct_count", n, 8);
    if (d == 1 && n > 0) chk("fp_first", 32'(gw[0]), 32'd0);
    for (int i = 1; i < n; i++) begin
      chk("ct_gap", gc[i] - gc[i-1], 2);
      if (d == 0) chk("rr_alternate", 32'(gw[i]), 32'(!gw[i-1]));
      else        chk("fp_req0_wins", 32'(gw[i]), 32'd0);
    end
  endtask

  task automatic drop_test(input int d);
    int g, n0, nce;
    logic [7:0] pre;
    pre = mem[d][14'h0055];
    fork
      access(d, 1, 1'b1, 14'h0777, 8'h66, 1'b0, g);
      begin
        for (int i = 0; i < 40 && !gnt[d][1]; i++) @(negedge clk);
        #1;
        we[d][0] = 1'b1; addr[d][0] = 14'h0055; wdata[d][0] = 8'h77;
        req[d][0] = 1'b1;
        @(negedge clk); #1;
        req[d][0] = 1'b0;
      end
    join
    n0 = 0; nce = 0;
    repeat (8) begin
      @(negedge clk);
      if (gnt[d][0]) n0++;
      if (mem_ce[d]) nce++;
    end
    chk("drop_gnt", n0, 0);
    chk("drop_ce", nce, 0);
    chk("drop_mem", 32'(mem[d][14'h0055]), 32'(pre));
    chk("drop_r1_write", 32'(mem[d][14'h0777]), 32'h66);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g0, g1, gx;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b1; req[d] = 2'b00; we[d] = 2'b00; oce_n[d] = 0;
      for (int r = 0; r < 2; r++) begin addr[d][r] = '0; wdata[d][r] = '0; end
    end
    #1;
    for (int d = 0; d < 2; d++) rst_n[d] = 1'b0;
    #1;
    // Reset is asynchronous: outputs are checked before any clock edge.
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", 32'(busy[d]), 32'd0);
      chk("rst_gnt_rvalid", 32'({gnt[d], rvalid[d]}), 32'd0);
      chk("rst_mem_ctl", 32'({mem_ce[d], mem_wre[d], mem_oce[d]}), 32'd0);
      chk("rst_ad_din", 32'({mem_ad[d], mem_din[d]}), 32'd0);
      chk("rst_rdata", 32'({rdata[d][0], rdata[d][1]}), 32'd0);
    end
    repeat (2) @(negedge clk);
    chk("mem_clk", 32'(mem_clk[0]), 32'(clk));
    for (int d = 0; d < 2; d++) rst_n[d] = 1'b1;

    // Write then read back, plus preload for later phases.
    for (int d = 0; d < 2; d++) begin
      access(d, 0, 1'b1, 14'h0010, 8'hA5, 1'b1, gx);
      access(d, 0, 1'b0, 14'h0010, 8'h00, 1'b1, gx);
      wait_idle(d);
      chk("r0_readback", 32'(rdata[d][0]), 32'hA5);
      access(d, 0, 1'b1, 14'h0000, 8'h11, 1'b1, gx);
      access(d, 0, 1'b1, 14'h3FFF, 8'h22, 1'b1, gx);
      access(d, 1, 1'b1, 14'h0200, 8'h5C, 1'b1, gx);
    end

    // Simultaneous reads straight after reset: requester 0 first.
    for (int d = 0; d < 2; d++) begin
      reset_dut(d);
      fork
        access(d, 0, 1'b0, 14'h0000, 8'h00, 1'b0, g0);
        access(d, 1, 1'b0, 14'h3FFF, 8'h00, 1'b0, g1);
      join
      wait_idle(d);
      chk("both_r0_first", 32'(g0 < g1), 32'd1);
      chk("both_r1_next_idle", g1, g0 + rl_of(d) + 2);
      chk("both_r0_keep", 32'(rdata[d][0]), 32'h11);
      chk("both_r1_data", 32'(rdata[d][1]), 32'h22);
    end

    // Asynchronous reset while a requester 1 read is waiting on memory.
    for (int d = 0; d < 2; d++) begin
      access(d, 1, 1'b0, 14'h3FFF, 8'h00, 1'b0, gx);
      rst_n[d] = 1'b0;
      clear_sb(d);
      #1;
      chk("arst_busy", 32'(busy[d]), 32'd0);
      chk("arst_ctl", 32'({rvalid[d], mem_oce[d], mem_ce[d]}), 32'd0);
      chk("arst_rdata", 32'({rdata[d][0], rdata[d][1]}), 32'd0);
      repeat (3) begin
        @(negedge clk);
        chk("arst_no_rvalid", 32'(rvalid[d]), 32'd0);
      end
      rst_n[d] = 1'b1;
      access(d, 1, 1'b0, 14'h3FFF, 8'h00, 1'b1, gx);
      wait_idle(d);
      chk("arst_reread", 32'(rdata[d][1]), 32'h22);
      chk("arst_r0_untouched", 32'(rdata[d][0]), 32'd0);
    end

    for (int d = 0; d < 2; d++) begin
      contend(d);
      wait_idle(d);
    end
    for (int d = 0; d < 2; d++) begin
      drop_test(d);
      wait_idle(d);
    end

    // 0x200 was only rewritten where requester 1 could win the conflict.
    for (int d = 0; d < 2; d++) begin
      access(d, 0, 1'b0, 14'h0200, 8'h00, 1'b1, gx);
      wait_idle(d);
      chk("final_0x200", 32'(rdata[d][0]), (d == 0) ? 32'h44 : 32'h5C);
      for (int k = 2 * d; k < 2 * d + 2; k++) chk("sb_empty", sb_q[k].size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
